// File: rtl/mult_control_if.sv
// Purpose : operator and datapath control bundle for the add-shift multiplier sequencer.
// Latency : pure wiring, no storage.
// Backpressure: none; Run is a level request and outputs are strobes.
// Ports   : i_run, i_clear_a_load_b, i_m flow into the sequencer;
//           o_clear_a, o_clr_ld, o_add, o_sub, o_load_a, o_load_x,
//           o_shift_en, o_busy, o_done flow out to the datapath and status logic.
interface mult_control_if;
  logic i_run;             // level start request, already debounced and synchronous
  logic i_clear_a_load_b;  // level operator command: clear A/X and load B
  logic i_m;               // multiplier LSB (Data_OutB[0])
  logic o_clear_a;         // clear A and X registers
  logic o_clr_ld;          // load B from switches
  logic o_add;             // select A+S into A/X
  logic o_sub;             // select A-S into A/X
  logic o_load_a;          // load A from adder result
  logic o_load_x;          // load X from adder sign bit
  logic o_shift_en;        // arithmetic right shift of X:A:B
  logic o_busy;            // multiply in progress
  logic o_done;            // multiply finished, waiting for Run release

  // The sequencer consumes the requests and produces the strobes.
  modport slave (
    input  i_run, i_clear_a_load_b, i_m,
    output o_clear_a, o_clr_ld, o_add, o_sub, o_load_a, o_load_x,
           o_shift_en, o_busy, o_done
  );

  // The operator/datapath side drives the requests and observes the strobes.
  modport master (
    output i_run, i_clear_a_load_b, i_m,
    input  o_clear_a, o_clr_ld, o_add, o_sub, o_load_a, o_load_x,
           o_shift_en, o_busy, o_done
  );
endinterface

// File: rtl/mult_control.sv
// Purpose : sequencing FSM for the 8-bit signed add-shift multiplier (CLR, then N_BITS x ADD/SHIFT).
// Latency : Done rises 2*N_BITS+1 cycles after Run is sampled; Busy is high for 2*N_BITS+1 cycles.
// Backpressure: none; the run completes unconditionally and parks in DONE until Run drops.
// Ports   : i_clk    - clock, all state on posedge
//           i_reset  - synchronous active-high reset, forces IDLE and clears the counter
//           bus      - mult_control_if.slave carrying Run/ClearA_LoadB/M in and the datapath strobes out
module mult_control #(
  parameter int N_BITS = 8  // multiplier width; must be >= 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mult_control_if.slave bus
);

  localparam int CW = $clog2(N_BITS);
  // Index of the final iteration: the multiplier sign bit, which carries negative weight.
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic   [CW-1:0] r_cnt;

  state_t          w_state_nxt;
  logic   [CW-1:0] w_cnt_nxt;
  logic            w_last;

  logic w_clear_a;
  logic w_clr_ld;
  logic w_add;
  logic w_sub;
  logic w_load_a;
  logic w_load_x;
  logic w_shift_en;
  logic w_busy;
  logic w_done;

  assign w_last = (r_cnt == LAST);

  // State register. Reset aborts a run in progress; the datapath registers keep
  // whatever they held because no further load/shift strobes are produced.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and output decode. Outputs are Moore except the ADD strobes
  // (gated by M) and the IDLE clear/load pair (gated by ClearA_LoadB).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clear_a   = 1'b0;
    w_clr_ld    = 1'b0;
    w_add       = 1'b0;
    w_sub       = 1'b0;
    w_load_a    = 1'b0;
    w_load_x    = 1'b0;
    w_shift_en  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Run wins over the clear/load command when both are requested.
        if (bus.i_run) begin
          w_state_nxt = S_CLR;
          w_cnt_nxt   = '0;
        end else if (bus.i_clear_a_load_b) begin
          w_clear_a = 1'b1;
          w_clr_ld  = 1'b1;
        end
      end

      S_CLR: begin
        w_clear_a   = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = S_ADD;
      end

      S_ADD: begin
        w_busy = 1'b1;
        // M is stable here because B only moves on Shift_En.
        if (bus.i_m) begin
          if (w_last) begin
            w_sub = 1'b1;
          end else begin
            w_add = 1'b1;
          end
        end
        w_load_a    = w_add | w_sub;
        w_load_x    = w_add | w_sub;
        w_state_nxt = S_SHIFT;
      end

      S_SHIFT: begin
        w_busy     = 1'b1;
        w_shift_en = 1'b1;
        // The counter stops at LAST so it can never wrap.
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = S_ADD;
        end
      end

      S_DONE: begin
        w_done = 1'b1;
        // One multiply per Run press: wait for release before re-arming.
        if (!bus.i_run) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.o_clear_a  = w_clear_a;
  assign bus.o_clr_ld   = w_clr_ld;
  assign bus.o_add      = w_add;
  assign bus.o_sub      = w_sub;
  assign bus.o_load_a   = w_load_a;
  assign bus.o_load_x   = w_load_x;
  assign bus.o_shift_en = w_shift_en;
  assign bus.o_busy     = w_busy;
  assign bus.o_done     = w_done;

  // Strobe pairs that would corrupt the datapath if they ever coincided.
  a_add_sub : assert property (@(posedge i_clk) !(w_add && w_sub));
  a_shift_load : assert property (@(posedge i_clk) !(w_shift_en && w_load_a));
  a_shift_clear : assert property (@(posedge i_clk) !(w_shift_en && w_clear_a));
  a_shift_clrld : assert property (@(posedge i_clk) !(w_shift_en && w_clr_ld));

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Sequencing FSM for the 8-bit add-shift signed multiplier datapath (X/A/B shift registers plus adder/subtractor).
- On each Run press it clears A and X, then performs N_BITS iterations of conditional add/subtract followed by an arithmetic right shift of X:A:B.
- Parks in a done state until Run is released.
- Outside a run, it also handles the combined "clear A / load B" operator command.

Parameters:
N_BITS, 8, multiplier width = number of add/shift iterations; legal range ≥2; iteration counter is $clog2(N_BITS) bits.

Ports:
Clk           input   1  system clock, all state on posedge
Reset         input   1  synchronous, active-high; forces IDLE
Run           input   1  level; start request (debounced, synchronous)
ClearA_LoadB  input   1  level; clear A/X and load B from switches, honoured only in IDLE
M             input   1  current multiplier LSB (Data_OutB[0])
ClearA        output  1  clears A and X registers (drives Reset_A)
Clr_Ld        output  1  load B register (drives LoadB)
Add           output  1  select A+S into A/X
Sub           output  1  select A-S into A/X
LoadA         output  1  load A from adder result
LoadX         output  1  load X from adder sign/carry bit
Shift_En      output  1  one-bit right shift of X:A:B
Busy          output  1  high in CLR, ADD, SHIFT
Done          output  1  high in DONE

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, DONE; iteration counter cnt.
- Reset sampled high: next state IDLE, cnt=0. All outputs are 0 in the cycle after reset, provided ClearA_LoadB=0.
- Reset mid-run aborts immediately. No further Shift_En/LoadA. Datapath contents are left as-is.
- IDLE:
  - Run=1 -> CLR, cnt=0.
  - Else if ClearA_LoadB=1: ClearA=1 and Clr_Ld=1 combinationally in the same cycle; stay IDLE.
  - Run has priority over ClearA_LoadB: if both are high, Clr_Ld=ClearA=0 and the FSM goes to CLR.
- CLR: ClearA=1 for exactly one cycle -> ADD.
- ADD (one cycle):
  - If M=1 and cnt<N_BITS-1: Add=1.
  - If M=1 and cnt=N_BITS-1: Sub=1 (multiplier sign bit has negative weight).
  - LoadA=LoadX=Add|Sub. If M=0, all four are 0.
  - Always -> SHIFT.
- SHIFT (one cycle):
  - Shift_En=1.
  - If cnt=N_BITS-1 -> DONE; else cnt<=cnt+1 -> ADD.
- DONE: Done=1. Stay while Run=1; Run=0 -> IDLE. One multiply per Run press; Run held high never restarts a run.
- Outputs:
  - All outputs are Moore (decoded from state/cnt), except Add/Sub/LoadA/LoadX, which are gated combinationally by M in ADD.
  - ClearA/Clr_Ld in IDLE are gated by ClearA_LoadB.
  - M is stable during ADD because B changes only on Shift_En.
- Mutual exclusion, never both high in the same cycle: Add/Sub; Shift_En/LoadA; Shift_En/ClearA; Clr_Ld/Shift_En.
- Latency: if Run is sampled at edge e0:
  - CLR occupies cycle e0..e1.
  - Iteration i has ADD after edge e(1+2i) and SHIFT after edge e(2+2i).
  - Done rises after edge e(2N_BITS+1): 17 cycles for N_BITS=8.
  - Busy is high for 2N_BITS+1 cycles.
- ClearA_LoadB is ignored while Busy or Done.
- cnt never wraps: it is reset on entry to CLR and is only incremented in SHIFT when cnt<N_BITS-1.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with Run=1 -> every output 0, Busy=0; release Reset with Run=0 -> IDLE, outputs stay 0.
- Clear/load: IDLE, ClearA_LoadB=1 for 1 cycle -> ClearA=1 and Clr_Ld=1 in that cycle only, state stays IDLE, Busy=0.
- Full run, N_BITS=8, M sequence modelled from B=0x85 shifting (per-ADD M = 1,0,1,0,0,0,0,1):
  - Add pulses at iterations 0 and 2; Sub pulse at iteration 7; LoadA/LoadX track Add|Sub.
  - Exactly 8 Shift_En pulses, never coincident with LoadA.
  - Done rises 17 cycles after Run is sampled.
- Run hold/re-arm: Run held high 10 cycles past Done -> Done stays 1, no Shift_En. Run=0 -> IDLE next cycle. Run=1 again -> new CLR with ClearA=1.
- Abort: Reset=1 in the ADD state of iteration 3 (M=1) -> IDLE next cycle, total Shift_En count 3, Busy=0, Done never asserted.
- Priority: Run=1 and ClearA_LoadB=1 in the same IDLE cycle -> Clr_Ld=0, FSM enters CLR. ClearA_LoadB=1 during SHIFT -> Clr_Ld stays 0.
